// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the 1-D convolution sequencer.
// Holds the FSM state enum, config-field indices and status/interrupt bit positions.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RUN,
    DRAIN,
    WRITE,
    DONE
  } conv_state_e;

  // Config register fields are packed at field_index * ADDR_WIDTH_MEMI.
  localparam int CFG_SX_FIELD    = 0;
  localparam int CFG_SY_FIELD    = 1;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int INT_DONE_BIT    = 0;
  localparam int INT_ERR_BIT     = 1;

endpackage

// File: rtl/conv_mac.sv
// conv_mac: signed multiply-accumulate with clear/enable and a DW-wide result view.
// Define CONV_SAT_EN to saturate the result; otherwise the low DW bits are returned.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DW    = 32,
  parameter int ACC_W = 70
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic          i_vld,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_res
);

  logic                    r_vld;
  logic                    r_frz;
  logic [DW-1:0]           r_ha, r_hb;
  logic signed [ACC_W-1:0] r_acc;

  logic [DW-1:0]           w_a, w_b;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;

  // The memories keep reading while frozen, so the operand pair that was on the
  // bus when the freeze began is held and used on the first enabled cycle.
  assign w_a        = r_frz ? r_ha : i_a;
  assign w_b        = r_frz ? r_hb : i_b;
  assign w_prod     = $signed(w_a) * $signed(w_b);
  assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_frz <= 1'b0;
      r_ha  <= '0;
      r_hb  <= '0;
      r_acc <= '0;
    end else begin
      r_frz <= !i_en;
      if (!r_frz) begin
        r_ha <= i_a;
        r_hb <= i_b;
      end
      if (i_en) begin
        r_vld <= i_vld;
        if (i_clr)      r_acc <= '0;
        else if (r_vld) r_acc <= r_acc + w_prod_ext;
      end
    end
  end

`ifdef CONV_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  always_comb begin
    o_res = r_acc[DW-1:0];
    if (r_acc > MAXV)      o_res = MAXV[DW-1:0];
    else if (r_acc < MINV) o_res = MINV[DW-1:0];
  end
`else
  logic w_unused_acc;
  assign w_unused_acc = ^r_acc[ACC_W-1:DW];
  assign o_res        = r_acc[DW-1:0];
`endif

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer for z[n] = sum_k x[k]*y[n-k]; drives X/Y reads, Z writes, MAC.
// Define CONV_SAT_EN to saturate Z results instead of wrapping.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH_MEMI = 6,
  parameter int ADDR_WIDTH_MEMO = 6,
  parameter int ACC_WIDTH       = 2*DATA_WIDTH+ADDR_WIDTH_MEMI
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_s,
  input  logic                       start,
  input  logic [31:0]                data_ConfigReg,
  output logic [ADDR_WIDTH_MEMI-1:0] memX_addr,
  input  logic [DATA_WIDTH-1:0]      dataX,
  output logic [ADDR_WIDTH_MEMI-1:0] memY_addr,
  input  logic [DATA_WIDTH-1:0]      dataY,
  output logic [ADDR_WIDTH_MEMO-1:0] memZ_addr,
  output logic [DATA_WIDTH-1:0]      dataZ,
  output logic                       writeZ,
  output logic [7:0]                 status_IPcore,
  output logic [7:0]                 int_IPcore
);

  localparam int AWI    = ADDR_WIDTH_MEMI;
  localparam int NW     = AWI + 1;
  localparam int SX_LSB = CFG_SX_FIELD * AWI;
  localparam int SY_LSB = CFG_SY_FIELD * AWI;

  conv_state_e    r_state, w_nxt;
  logic [AWI-1:0] r_sx, r_sy, r_k, r_kmax;
  logic [NW-1:0]  r_n;
  logic           r_err;

  logic [AWI-1:0]        w_cfg_sx, w_cfg_sy, w_kmin, w_kmax;
  logic [NW-1:0]         w_tot, w_nlast, w_np1;
  logic                  w_zero, w_big, w_unused_cfg;
  logic [DATA_WIDTH-1:0] w_res;

  assign w_cfg_sx     = data_ConfigReg[SX_LSB +: AWI];
  assign w_cfg_sy     = data_ConfigReg[SY_LSB +: AWI];
  assign w_unused_cfg = ^data_ConfigReg[31:2*AWI];

  assign w_tot  = {1'b0, w_cfg_sx} + {1'b0, w_cfg_sy};
  assign w_zero = (w_cfg_sx == '0) || (w_cfg_sy == '0);
  // SX+SY-1 outputs must fit in the Z memory.
  assign w_big  = 32'(w_tot) > 32'(2**ADDR_WIDTH_MEMO) + 32'd1;

  assign w_nlast = {1'b0, r_sx} + {1'b0, r_sy} - NW'(2);
  assign w_np1   = r_n + NW'(1);
  assign w_kmin  = (w_np1 > {1'b0, r_sy}) ? AWI'(w_np1 - {1'b0, r_sy}) : '0;
  assign w_kmax  = (r_n < {1'b0, r_sx}) ? AWI'(r_n) : r_sx - AWI'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_state <= IDLE;
    else if (en_s) r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_nxt = (w_zero || w_big) ? DONE : SETUP;
      SETUP:   w_nxt = RUN;
      RUN:     if (r_k == r_kmax) w_nxt = DRAIN;
      DRAIN:   w_nxt = WRITE;
      WRITE:   w_nxt = (r_n == w_nlast) ? DONE : SETUP;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_k    <= '0;
      r_kmax <= '0;
      r_n    <= '0;
      r_err  <= 1'b0;
    end else if (en_s) begin
      case (r_state)
        IDLE: if (start) begin
          r_sx  <= w_cfg_sx;
          r_sy  <= w_cfg_sy;
          r_err <= !w_zero && w_big;
          r_n   <= '0;
        end
        SETUP: begin
          r_k    <= w_kmin;
          r_kmax <= w_kmax;
        end
        RUN:     r_k <= r_k + AWI'(1);
        WRITE:   if (r_n != w_nlast) r_n <= r_n + NW'(1);
        default: ;
      endcase
    end
  end

  conv_mac #(
    .DW    (DATA_WIDTH),
    .ACC_W (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (en_s),
    .i_clr (r_state == SETUP),
    .i_vld (r_state == RUN),
    .i_a   (dataX),
    .i_b   (dataY),
    .o_res (w_res)
  );

  // n-k is at most SY-1, so the modulo-2**AWI difference is exact.
  assign memX_addr = (r_state == RUN) ? r_k : '0;
  assign memY_addr = (r_state == RUN) ? (r_n[AWI-1:0] - r_k) : '0;
  assign writeZ    = (r_state == WRITE);
  assign memZ_addr = writeZ ? ADDR_WIDTH_MEMO'(r_n) : '0;
  assign dataZ     = writeZ ? w_res : '0;

  always_comb begin
    status_IPcore                  = '0;
    status_IPcore[STATUS_BUSY_BIT] = (r_state != IDLE);
    int_IPcore                     = '0;
    int_IPcore[INT_DONE_BIT]       = (r_state == DONE);
    int_IPcore[INT_ERR_BIT]        = (r_state == DONE) && r_err;
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: scoreboard bench for conv_seq_ctrl with sync-read X/Y memory models.
// Build with CONV_SAT_EN defined to expect saturated results.
module tb_conv_seq_ctrl;
  localparam int DW = 32, AWI = 6, AWO = 6;

  typedef struct packed {
    logic [AWO-1:0] a;
    logic [DW-1:0]  d;
  } wr_t;

  logic clk = 1'b0, rst_n = 1'b0, en_s = 1'b1, start = 1'b0;
  logic [31:0] cfg = '0;
  logic [AWI-1:0] memX_addr, memY_addr;
  logic [DW-1:0]  dataX = '0, dataY = '0;
  logic [AWO-1:0] memZ_addr;
  logic [DW-1:0]  dataZ;
  logic           writeZ;
  logic [7:0]     status, intr;
  logic [DW-1:0]  memX [0:63];
  logic [DW-1:0]  memY [0:63];

  wr_t exp_q[$], obs_q[$];
  int cyc = 0, chk = 0, pass = 0, st = 0;
  int done_cnt = 0, err_cnt = 0, err_only = 0, busy_cnt = 0, last_wr = 0, done_cyc = 0;

  conv_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en_s(en_s), .start(start), .data_ConfigReg(cfg),
    .memX_addr(memX_addr), .dataX(dataX), .memY_addr(memY_addr), .dataY(dataY),
    .memZ_addr(memZ_addr), .dataZ(dataZ), .writeZ(writeZ),
    .status_IPcore(status), .int_IPcore(intr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    dataX <= memX[memX_addr];
    dataY <= memY[memY_addr];
  end

  always @(negedge clk) begin
    if (writeZ && en_s) begin
      obs_q.push_back(wr_t'{memZ_addr, dataZ});
      last_wr = cyc;
    end
    if (intr[0]) begin done_cnt++; done_cyc = cyc; end
    if (intr[1]) begin err_cnt++; if (!intr[0]) err_only++; end
    if (status[0]) busy_cnt++;
  end

  function automatic void model_push(input int sx, input int sy);
    for (int n = 0; n <= sx + sy - 2; n++) begin
      longint s;
      logic [DW-1:0] d;
      s = 0;
      for (int k = 0; k < sx; k++)
        if (n - k >= 0 && n - k < sy)
          s += longint'($signed(memX[k])) * longint'($signed(memY[n-k]));
`ifdef CONV_SAT_EN
      if (s > 64'sh7FFF_FFFF)        d = 32'h7FFF_FFFF;
      else if (s < -64'sh8000_0000)  d = 32'h8000_0000;
      else                           d = s[31:0];
`else
      d = s[31:0];
`endif
      exp_q.push_back(wr_t'{AWO'(n), d});
    end
  endfunction

  task automatic start_op(input int sx, input int sy);
    @(negedge clk);
    cfg   = (32'(sy) << AWI) | 32'(sx);
    start = 1'b1;
    st    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string nm);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin @(negedge clk); n++; end
    chk++;
    if (done_cnt == d0) $display("FAIL %s_timeout: no done within %0d cycles", nm, budget);
    else pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_case1();
    memX[0] = 1; memX[1] = 2; memX[2] = 3;
    memY[0] = 1; memY[1] = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk++; if ({writeZ, status, intr} !== '0) $display("FAIL rst_ctl got %h exp 0", {writeZ, status, intr}); else pass++;
    chk++; if ({memX_addr, memY_addr, memZ_addr} !== '0) $display("FAIL rst_addr got %h exp 0", {memX_addr, memY_addr, memZ_addr}); else pass++;
    chk++; if (dataZ !== '0) $display("FAIL rst_dataZ got %h exp 0", dataZ); else pass++;
  endtask

  task automatic test_basic();
    int d0;
    wr_t e, o;
    load_case1();
    exp_q.push_back(wr_t'{6'd0, 32'd1}); exp_q.push_back(wr_t'{6'd1, 32'd3});
    exp_q.push_back(wr_t'{6'd2, 32'd5}); exp_q.push_back(wr_t'{6'd3, 32'd3});
    d0 = done_cnt;
    start_op(3, 2);
    wait_done(d0, 200, "basic");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.size() ? obs_q.pop_front() : wr_t'('1); chk++;
      if (o !== e) $display("FAIL basic_z got a=%0d d=%h exp a=%0d d=%h", o.a, o.d, e.a, e.d); else pass++;
    end
    chk++; if (obs_q.size() != 0) $display("FAIL basic_extra got %0d exp 0", obs_q.size()); else pass++;
    chk++; if (last_wr - st != 18) $display("FAIL basic_lastwr got %0d exp 18", last_wr - st); else pass++;
    chk++; if (done_cnt - d0 != 1) $display("FAIL basic_donecnt got %0d exp 1", done_cnt - d0); else pass++;
    chk++; if (done_cyc - st != 19) $display("FAIL basic_donecyc got %0d exp 19", done_cyc - st); else pass++;
  endtask

  task automatic test_single();
    int d0, b0;
    wr_t e, o;
    memX[0] = -32'sd2; memY[0] = 32'd3;
    exp_q.push_back(wr_t'{6'd0, 32'hFFFF_FFFA});
    d0 = done_cnt; b0 = busy_cnt;
    start_op(1, 1);
    wait_done(d0, 50, "single");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.size() ? obs_q.pop_front() : wr_t'('1); chk++;
      if (o !== e) $display("FAIL single_z got a=%0d d=%h exp a=%0d d=%h", o.a, o.d, e.a, e.d); else pass++;
    end
    chk++; if (obs_q.size() != 0) $display("FAIL single_extra got %0d exp 0", obs_q.size()); else pass++;
    chk++; if (busy_cnt - b0 != 5) $display("FAIL single_busy got %0d exp 5", busy_cnt - b0); else pass++;
  endtask

  task automatic test_empty_err();
    int d0, e0, eo0;
    d0 = done_cnt; e0 = err_cnt; eo0 = err_only;
    start_op(0, 4);
    wait_done(d0, 20, "zero");
    chk++; if (obs_q.size() != 0) $display("FAIL zero_writes got %0d exp 0", obs_q.size()); else pass++;
    chk++; if (done_cyc - st != 1) $display("FAIL zero_donecyc got %0d exp 1", done_cyc - st); else pass++;
    chk++; if (err_cnt != e0) $display("FAIL zero_err got %0d exp 0", err_cnt - e0); else pass++;
    d0 = done_cnt;
    start_op(40, 40);
    wait_done(d0, 20, "big");
    chk++; if (obs_q.size() != 0) $display("FAIL big_writes got %0d exp 0", obs_q.size()); else pass++;
    chk++; if (err_cnt - e0 != 1) $display("FAIL big_err got %0d exp 1", err_cnt - e0); else pass++;
    chk++; if (err_only != eo0) $display("FAIL big_err_alone got %0d exp 0", err_only - eo0); else pass++;
    d0 = done_cnt; e0 = err_cnt;
    start_op(33, 33);
    wait_done(d0, 20, "big65");
    chk++; if (obs_q.size() != 0 || err_cnt - e0 != 1) $display("FAIL big65 got writes=%0d err=%0d exp 0/1", obs_q.size(), err_cnt - e0); else pass++;
    obs_q.delete();
  endtask

  task automatic test_sat();
    int d0;
    wr_t e, o;
    memX[0] = 32'h7FFF_FFFF; memY[0] = 32'd2;
`ifdef CONV_SAT_EN
    exp_q.push_back(wr_t'{6'd0, 32'h7FFF_FFFF});
`else
    exp_q.push_back(wr_t'{6'd0, 32'hFFFF_FFFE});
`endif
    d0 = done_cnt;
    start_op(1, 1);
    wait_done(d0, 50, "sat");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.size() ? obs_q.pop_front() : wr_t'('1); chk++;
      if (o !== e) $display("FAIL sat_z got a=%0d d=%h exp a=%0d d=%h", o.a, o.d, e.a, e.d); else pass++;
    end
    chk++; if (obs_q.size() != 0) $display("FAIL sat_extra got %0d exp 0", obs_q.size()); else pass++;
  endtask

  task automatic test_freeze();
    int d0;
    wr_t e, o;
    load_case1();
    exp_q.push_back(wr_t'{6'd0, 32'd1}); exp_q.push_back(wr_t'{6'd1, 32'd3});
    exp_q.push_back(wr_t'{6'd2, 32'd5}); exp_q.push_back(wr_t'{6'd3, 32'd3});
    d0 = done_cnt;
    start_op(3, 2);
    repeat (2) @(negedge clk);
    cfg = (32'd1 << AWI) | 32'd1;   // start and new config while busy
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);       // cycle 7: second RUN cycle of n=1
    en_s = 1'b0;
    repeat (3) @(negedge clk);
    en_s = 1'b1;
    wait_done(d0, 200, "freeze");
    repeat (10) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.size() ? obs_q.pop_front() : wr_t'('1); chk++;
      if (o !== e) $display("FAIL freeze_z got a=%0d d=%h exp a=%0d d=%h", o.a, o.d, e.a, e.d); else pass++;
    end
    chk++; if (obs_q.size() != 0) $display("FAIL freeze_extra got %0d exp 0", obs_q.size()); else pass++;
    chk++; if (last_wr - st != 21) $display("FAIL freeze_lastwr got %0d exp 21", last_wr - st); else pass++;
    chk++; if (done_cnt - d0 != 1) $display("FAIL freeze_donecnt got %0d exp 1", done_cnt - d0); else pass++;
  endtask

  task automatic test_reset_mid();
    int d0;
    wr_t e, o;
    load_case1();
    d0 = done_cnt;
    start_op(3, 2);
    repeat (8) @(negedge clk);       // cycle 9: WRITE of n=1
    chk++; if (writeZ !== 1'b1 || memZ_addr !== 6'd1) $display("FAIL rmid_write got w=%b a=%0d exp 1/1", writeZ, memZ_addr); else pass++;
    #2 rst_n = 1'b0;
    #1;
    chk++; if ({writeZ, status, intr, dataZ} !== '0) $display("FAIL rmid_out got %h exp 0", {writeZ, status, intr, dataZ}); else pass++;
    chk++; if ({memX_addr, memY_addr, memZ_addr} !== '0) $display("FAIL rmid_addr got %h exp 0", {memX_addr, memY_addr, memZ_addr}); else pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk++; if (done_cnt != d0 || status[0] !== 1'b0) $display("FAIL rmid_idle got done=%0d busy=%b exp 0/0", done_cnt - d0, status[0]); else pass++;
    obs_q.delete();
    exp_q.push_back(wr_t'{6'd0, 32'd1}); exp_q.push_back(wr_t'{6'd1, 32'd3});
    exp_q.push_back(wr_t'{6'd2, 32'd5}); exp_q.push_back(wr_t'{6'd3, 32'd3});
    d0 = done_cnt;
    start_op(3, 2);
    wait_done(d0, 200, "rmid_rerun");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.size() ? obs_q.pop_front() : wr_t'('1); chk++;
      if (o !== e) $display("FAIL rmid_z got a=%0d d=%h exp a=%0d d=%h", o.a, o.d, e.a, e.d); else pass++;
    end
    chk++; if (obs_q.size() != 0) $display("FAIL rmid_extra got %0d exp 0", obs_q.size()); else pass++;
    chk++; if (last_wr - st != 18) $display("FAIL rmid_lastwr got %0d exp 18", last_wr - st); else pass++;
  endtask

  task automatic test_random();
    int d0, sx, sy;
    wr_t e, o;
    for (int it = 0; it < 4; it++) begin
      sx = (it == 3) ? 33 : int'($urandom_range(1, 8));
      sy = (it == 3) ? 32 : int'($urandom_range(1, 8));
      for (int i = 0; i < 64; i++) begin
        memX[i] = 32'(int'($urandom_range(0, 2097151)) - 1048576);
        memY[i] = 32'(int'($urandom_range(0, 2097151)) - 1048576);
      end
      model_push(sx, sy);
      d0 = done_cnt;
      start_op(sx, sy);
      wait_done(d0, 3000, "rand");
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.size() ? obs_q.pop_front() : wr_t'('1); chk++;
        if (o !== e) $display("FAIL rand_z sx=%0d sy=%0d got a=%0d d=%h exp a=%0d d=%h", sx, sy, o.a, o.d, e.a, e.d); else pass++;
      end
      chk++; if (obs_q.size() != 0) $display("FAIL rand_extra got %0d exp 0", obs_q.size()); else pass++;
      obs_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin memX[i] = '0; memY[i] = '0; end
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_basic();
    test_single();
    test_empty_err();
    test_sat();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass, chk);
    $fatal(1);
  end

endmodule
